cpc_pi_mailbox_ctrl: RTL and testbench

- CPLD-resident controller that shares a byte-wide mailbox between the CPC Z80 I/O bus and the Raspberry Pi GPIO bus.
- Decodes Z80 IOREQ_B/RD_B/WR_B cycles at a fixed port pair.
- Buffers bytes in two small FIFOs, one per direction.
- Runs a synchronised 4-phase req/ack handshake toward the Pi, which is asynchronous to CLK.

---
 rtl/cpc_pi_mailbox_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cpc_pi_mailbox_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_pi_mailbox_ctrl.sv
// Byte mailbox between the CPC Z80 I/O bus and the Raspberry Pi GPIO handshake.
// Latency: PI_REQ rise to PI_ACK rise is 4 CLK edges; Z80 data/status reads are combinational.
// Backpressure: a Z80 write into a full tx FIFO sets ovf; a Pi write into a full rx FIFO is dropped.

module cpc_pi_mailbox_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_vld,
    input  logic [7:0] push_dat,
    input  logic       pop_vld,
    output logic [7:0] head_dat,
    output logic       full,
    output logic       empty
);
    // Generic byte FIFO: pointers wrap modulo DEPTH, count holds 0..DEPTH.
    // Latency: a push is visible at head on the next cycle when the FIFO was empty.
    // Backpressure: pushes into a full FIFO are accepted only alongside a same-cycle pop.

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop_vld && !empty;
    assign push_ok  = push_vld && (!full || pop_ok);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module cpc_pi_mailbox_ctrl #(
    parameter logic [15:0] PORT_ADDR = 16'hFD80,
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  EMPTY_RD  = 8'hFF
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        PI_REQ,
    input  logic        PI_DIR,
    input  logic [7:0]  PI_DIN,
    output logic [7:0]  PI_DOUT,
    output logic        PI_ACK,
    output logic        PI_TXAV,
    output logic        PI_RXFULL
);
    // Top: Z80 port decode, two mailbox FIFOs and the Pi req/ack state machine.
    // Latency: 4 CLK edges PI_REQ->PI_ACK; Z80 pushes on leading edge, pops on trailing edge.
    // Backpressure: tx overflow latches ovf until a status read; rx overflow drops silently.

    typedef enum logic [1:0] {IDLE, XFER, ACKW} pi_state_t;

    pi_state_t  state;
    logic       sel, io_rd, io_wr, io_rd_q, io_wr_q, rd_a0_q;
    logic       z80_push, rd_end, ovf;
    logic       req_meta, req_s, req_armed;
    logic       xfer;
    logic [7:0] tx_head, rx_head;
    logic       tx_full, tx_empty, rx_full, rx_empty;

    assign sel   = !IOREQ_B && (A[15:1] == PORT_ADDR[15:1]);
    assign io_rd = sel && !RD_B;
    assign io_wr = sel && !WR_B;
    assign D_OE  = io_rd;

    assign z80_push = io_wr && !io_wr_q && !A[0];
    assign rd_end   = io_rd_q && !io_rd;
    assign xfer     = (state == XFER);

    always_comb begin
        D_OUT = rx_empty ? EMPTY_RD : rx_head;
        if (A[0]) D_OUT = {5'b0, ovf, tx_full, !rx_empty};
    end

    cpc_pi_mailbox_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk      (CLK),
        .rst_n    (RESET_B),
        .push_vld (z80_push),
        .push_dat (D_IN),
        .pop_vld  (xfer && PI_DIR),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    cpc_pi_mailbox_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk      (CLK),
        .rst_n    (RESET_B),
        .push_vld (xfer && !PI_DIR),
        .push_dat (PI_DIN),
        .pop_vld  (rd_end && !rd_a0_q),
        .head_dat (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_B) begin
            io_rd_q   <= 1'b0;
            io_wr_q   <= 1'b0;
            rd_a0_q   <= 1'b0;
            ovf       <= 1'b0;
            PI_TXAV   <= 1'b0;
            PI_RXFULL <= 1'b0;
        end else begin
            io_rd_q   <= io_rd;
            io_wr_q   <= io_wr;
            if (io_rd) rd_a0_q <= A[0];
            // Setting beats clearing when an overflow lands on the status-read trailing edge.
            if (z80_push && tx_full && !(xfer && PI_DIR))
                ovf <= 1'b1;
            else if (rd_end && rd_a0_q)
                ovf <= 1'b0;
            PI_TXAV   <= !tx_empty;
            PI_RXFULL <= rx_full;
        end
    end

    // Synchroniser resets high so a request still held across reset needs a fresh rise.
    always_ff @(posedge CLK) begin
        if (!RESET_B) begin
            req_meta  <= 1'b1;
            req_s     <= 1'b1;
            req_armed <= 1'b0;
            state     <= IDLE;
            PI_ACK    <= 1'b0;
            PI_DOUT   <= 8'h00;
        end else begin
            req_meta <= PI_REQ;
            req_s    <= req_meta;
            if (!req_s) req_armed <= 1'b1;
            case (state)
                IDLE: begin
                    PI_ACK <= 1'b0;
                    if (req_s && req_armed) state <= XFER;
                end
                XFER: begin
                    if (PI_DIR) PI_DOUT <= tx_empty ? EMPTY_RD : tx_head;
                    PI_ACK <= 1'b1;
                    state  <= ACKW;
                end
                ACKW: begin
                    if (!req_s) begin
                        PI_ACK <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    PI_ACK <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpc_pi_mailbox_ctrl.sv
// Scoreboard bench for cpc_pi_mailbox_ctrl: Z80 and Pi transactions against queue models.
module tb_cpc_pi_mailbox_ctrl;
    logic        CLK = 1'b0;
    logic        RESET_B = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D_IN = 8'h00;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        IOREQ_B = 1'b1;
    logic        RD_B = 1'b1;
    logic        WR_B = 1'b1;
    logic        PI_REQ = 1'b0;
    logic        PI_DIR = 1'b0;
    logic [7:0]  PI_DIN = 8'h00;
    logic [7:0]  PI_DOUT;
    logic        PI_ACK;
    logic        PI_TXAV;
    logic        PI_RXFULL;

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         ovf_m = 1'b0;

    cpc_pi_mailbox_ctrl dut (
        .CLK(CLK), .RESET_B(RESET_B), .A(A), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
        .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .PI_REQ(PI_REQ), .PI_DIR(PI_DIR),
        .PI_DIN(PI_DIN), .PI_DOUT(PI_DOUT), .PI_ACK(PI_ACK), .PI_TXAV(PI_TXAV),
        .PI_RXFULL(PI_RXFULL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {5'b0, ovf_m, tx_q.size() == 4, rx_q.size() != 0};
    endfunction

    function automatic logic [7:0] pop_exp(inout logic [7:0] q[$]);
        if (q.size() == 0) return 8'hFF;
        return q.pop_front();
    endfunction

    task automatic z80_out(input logic [15:0] addr, input logic [7:0] dat, input int wait_cyc);
        @(negedge CLK);
        A = addr; D_IN = dat; IOREQ_B = 1'b0; WR_B = 1'b0;
        repeat (wait_cyc) @(negedge CLK);
        IOREQ_B = 1'b1; WR_B = 1'b1;
        @(negedge CLK);
        if (addr == 16'hFD80) begin
            if (tx_q.size() < 4) tx_q.push_back(dat);
            else ovf_m = 1'b1;
        end
    endtask

    task automatic z80_in(input logic [15:0] addr, output logic [7:0] dat);
        @(negedge CLK);
        A = addr; IOREQ_B = 1'b0; RD_B = 1'b0;
        @(negedge CLK);
        dat = D_OUT;
        check("d_oe_rd", {15'b0, D_OE}, 16'd1);
        @(negedge CLK);
        IOREQ_B = 1'b1; RD_B = 1'b1;
        @(negedge CLK);
    endtask

    task automatic rd_data(input string tag);
        logic [7:0] v;
        logic [7:0] e;
        e = pop_exp(rx_q);
        z80_in(16'hFD80, v);
        check(tag, {8'h00, v}, {8'h00, e});
    endtask

    task automatic rd_status(input string tag);
        logic [7:0] v;
        logic [7:0] e;
        e = exp_status();
        z80_in(16'hFD81, v);
        ovf_m = 1'b0;
        check(tag, {8'h00, v}, {8'h00, e});
    endtask

    task automatic pi_xfer(input string tag, input logic dir, input logic [7:0] din);
        int lat;
        logic [7:0] e;
        @(negedge CLK);
        PI_DIR = dir; PI_DIN = din; PI_REQ = 1'b1;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!PI_ACK && lat < 20);
        check({tag, "_lat"}, 16'(lat), 16'd4);
        if (dir) begin
            e = pop_exp(tx_q);
            check({tag, "_dout"}, {8'h00, PI_DOUT}, {8'h00, e});
        end else if (rx_q.size() < 4) begin
            rx_q.push_back(din);
        end
        PI_REQ = 1'b0;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (PI_ACK && lat < 20);
        check({tag, "_ackdrop"}, {15'b0, PI_ACK}, 16'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] e;
        int lat;
        bit ack_seen;

        // Reset
        repeat (2) @(negedge CLK);
        check("rst_ack", {15'b0, PI_ACK}, 16'd0);
        check("rst_doe", {15'b0, D_OE}, 16'd0);
        check("rst_txav", {15'b0, PI_TXAV}, 16'd0);
        check("rst_rxfull", {15'b0, PI_RXFULL}, 16'd0);
        check("rst_dout", {8'h00, PI_DOUT}, 16'h0000);
        RESET_B = 1'b1;
        repeat (3) @(negedge CLK);
        rd_status("rst_status");
        rd_data("rst_empty_data");

        // Accesses outside the decoded pair
        @(negedge CLK);
        A = 16'hFD82; IOREQ_B = 1'b0; RD_B = 1'b0;
        @(negedge CLK);
        check("undecoded_doe", {15'b0, D_OE}, 16'd0);
        IOREQ_B = 1'b1; RD_B = 1'b1;
        z80_out(16'hFD82, 8'h77, 2);
        z80_out(16'hFD81, 8'h66, 2);
        repeat (2) @(negedge CLK);
        check("undecoded_txav", {15'b0, PI_TXAV}, 16'd0);

        // Z80 -> Pi with a stretched write
        z80_out(16'hFD80, 8'h5A, 3);
        @(negedge CLK);
        check("txav_set", {15'b0, PI_TXAV}, 16'd1);
        pi_xfer("pi_rd1", 1'b1, 8'h00);
        check("txav_clr", {15'b0, PI_TXAV}, 16'd0);

        // Pi -> Z80
        pi_xfer("pi_wr11", 1'b0, 8'h11);
        pi_xfer("pi_wr22", 1'b0, 8'h22);
        pi_xfer("pi_wr33", 1'b0, 8'h33);
        rd_status("rx_status");
        for (int i = 0; i < 4; i++) rd_data("rx_data");
        rd_status("rx_status_empty");

        // Overflow and pointer wrap
        for (int i = 0; i < 5; i++) z80_out(16'hFD80, 8'hA0 + 8'(i), 1);
        rd_status("ovf_status");
        rd_status("ovf_cleared");
        for (int i = 0; i < 4; i++) pi_xfer("drain", 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            z80_out(16'hFD80, 8'hC0 + 8'(i), 2);
            pi_xfer("wrap", 1'b1, 8'h00);
        end
        check("wrap_txav", {15'b0, PI_TXAV}, 16'd0);

        // Simultaneous Z80 pop and Pi push on a full rx FIFO
        for (int i = 0; i < 4; i++) pi_xfer("fill", 1'b0, 8'hB0 + 8'(i));
        check("rxfull_set", {15'b0, PI_RXFULL}, 16'd1);
        @(negedge CLK);
        PI_DIR = 1'b0; PI_DIN = 8'hAA; PI_REQ = 1'b1;
        A = 16'hFD80; IOREQ_B = 1'b0; RD_B = 1'b0;
        @(negedge CLK);
        e = pop_exp(rx_q);
        check("simul_head", {8'h00, D_OUT}, {8'h00, e});
        repeat (2) @(negedge CLK);
        IOREQ_B = 1'b1; RD_B = 1'b1;
        lat = 3;
        do begin
            @(negedge CLK);
            lat++;
        end while (!PI_ACK && lat < 20);
        check("simul_lat", 16'(lat), 16'd4);
        rx_q.push_back(8'hAA);
        PI_REQ = 1'b0;
        repeat (5) @(negedge CLK);
        check("simul_rxfull", {15'b0, PI_RXFULL}, 16'd1);
        for (int i = 0; i < 4; i++) rd_data("simul_data");
        check("simul_rxfull_clr", {15'b0, PI_RXFULL}, 16'd0);

        // Reset in the middle of a handshake
        z80_out(16'hFD80, 8'hE1, 1);
        z80_out(16'hFD80, 8'hE2, 1);
        pi_xfer("pre_rst_wr", 1'b0, 8'h99);
        @(negedge CLK);
        PI_DIR = 1'b1; PI_REQ = 1'b1;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!PI_ACK && lat < 20);
        check("mid_ack_up", {15'b0, PI_ACK}, 16'd1);
        RESET_B = 1'b0;
        @(negedge CLK);
        check("mid_rst_ack", {15'b0, PI_ACK}, 16'd0);
        RESET_B = 1'b1;
        tx_q.delete(); rx_q.delete(); ovf_m = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (PI_ACK) ack_seen = 1'b1;
        end
        check("held_req_no_ack", {15'b0, ack_seen}, 16'd0);
        check("mid_rst_txav", {15'b0, PI_TXAV}, 16'd0);
        rd_status("mid_rst_status");
        rd_data("mid_rst_data");
        PI_REQ = 1'b0;
        repeat (4) @(negedge CLK);
        z80_out(16'hFD80, 8'h3C, 1);
        pi_xfer("post_rst_rd", 1'b1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
